// File: rtl/breath_pkg.sv
// Shared encodings and helpers for the breathing-LED PWM controller and its channels.
package breath_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_SOLID   = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Start-of-ramp offset that spreads the channels evenly across the duty range.
  function automatic int unsigned phase_offset(input int unsigned ch,
                                               input int unsigned num_ch,
                                               input int unsigned pwm_bits);
    return ch * ((32'd1 << pwm_bits) / num_ch);
  endfunction

endpackage

// File: rtl/breath_channel.sv
// One LED channel: triangle-ramping duty/direction registers plus the registered LED compare.
module breath_channel
  import breath_pkg::*;
#(
  parameter int                  PWM_BITS  = 8,
  parameter logic [PWM_BITS-1:0] INIT_DUTY = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wrap,
  input  logic [1:0]          mode_q,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] duty;
  logic                dir;
  logic                ramp_p0;
  logic [PWM_BITS:0]   step_p0;
  logic                led_p0;

  // The direction flips on the same update that reaches a rail; a start value
  // already sitting on a rail turns around instead of wrapping.
  function automatic logic [PWM_BITS:0] ramp_step(input logic                d,
                                                  input logic [PWM_BITS-1:0] v);
    logic [PWM_BITS-1:0] nv;
    logic                nd;
    if (d == DIR_UP) begin
      nv = (v == DUTY_MAX) ? v - DUTY_ONE : v + DUTY_ONE;
      nd = (nv == DUTY_MAX || v == DUTY_MAX) ? DIR_DOWN : DIR_UP;
    end else begin
      nv = (v == '0) ? v + DUTY_ONE : v - DUTY_ONE;
      nd = (nv == '0 || v == '0) ? DIR_UP : DIR_DOWN;
    end
    return {nd, nv};
  endfunction

  assign ramp_p0 = wrap && (mode_q == MODE_BREATHE || mode_q == MODE_BLINK);
  assign step_p0 = ramp_step(dir, duty);

  always_comb begin
    led_p0 = 1'b0;
    if (en) begin
      case (mode_q)
        MODE_SOLID:   led_p0 = 1'b1;
        MODE_BREATHE: led_p0 = (pwm_cnt < duty);
        MODE_BLINK:   led_p0 = (dir == DIR_UP);
        default:      led_p0 = 1'b0;
      endcase
    end
  end

  // stage p0 -> p1: duty/dir advance once per period, LED drive registered
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= INIT_DUTY;
      dir  <= DIR_UP;
      led  <= 1'b0;
    end else begin
      if (ramp_p0) begin
        duty <= step_p0[PWM_BITS-1:0];
        dir  <= step_p0[PWM_BITS];
      end
      led <= led_p0;
    end
  end

endmodule

// File: rtl/breath_led_pwm.sv
// Multi-channel PWM breathing-LED controller: prescaler and shared PWM counter feeding
// NUM_CH phase-staggered breath_channel instances.
module breath_led_pwm
  import breath_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8,
  parameter int CLK_DIV  = 1000,
  parameter int DIV_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [NUM_CH-1:0] led,
  output logic              tick_out,
  output logic              period_done
);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [DIV_W-1:0]    prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [1:0]          mode_q;
  logic                tick_p0;
  logic                wrap_p0;

  // Gating the tick with en freezes every counter downstream while disabled.
  assign tick_p0 = en && (prescaler == DIV_LAST);
  assign wrap_p0 = tick_p0 && (pwm_cnt == CNT_MAX);

  // stage p0 -> p1: counters advance, pulses registered, mode latched at period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      pwm_cnt     <= '0;
      mode_q      <= MODE_OFF;
      tick_out    <= 1'b0;
      period_done <= 1'b0;
    end else begin
      tick_out    <= tick_p0;
      period_done <= wrap_p0;
      if (en) prescaler <= tick_p0 ? '0 : prescaler + DIV_ONE;
      if (tick_p0) pwm_cnt <= pwm_cnt + CNT_ONE;
      if (wrap_p0) mode_q <= mode;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    breath_channel #(
      .PWM_BITS  (PWM_BITS),
      .INIT_DUTY (PWM_BITS'(phase_offset(i, NUM_CH, PWM_BITS)))
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wrap    (wrap_p0),
      .mode_q  (mode_q),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule

// File: doc/breath_led_pwm.md
Name: breath_led_pwm

Overview:
Multi-channel PWM breathing-LED controller: the parametrised successor to the single-channel toggle/counter LED block. A prescaler feeds a shared PWM counter. Per-channel duty registers ramp up and down in a triangle, giving a true brightness "breath". The block adds selectable modes, per-channel phase staggering, an enable and a period marker, and sits between the board clock and the LED pins.

Parameters:
NUM_CH, 4, number of LED channels (1..16).
PWM_BITS, 8, width of the PWM counter and duty registers; PWM period = 2^PWM_BITS ticks.
CLK_DIV, 1000, clk cycles per PWM tick (>=1).
DIV_W, 16, prescaler counter width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  reset; one clock; reset is synchronous and active-high.
en  input  1  run enable; low freezes all counters and forces led to 0.
mode  input  2  0 = off, 1 = solid on, 2 = breathe, 3 = blink.
led  output  NUM_CH  registered LED drive, one bit per channel.
tick_out  output  1  one-clk pulse per PWM tick; replaces the legacy clk_out.
period_done  output  1  one-clk pulse when the PWM counter wraps.

Behaviour:
- Reset (rst=1 at posedge) sets: prescaler=0, pwm_cnt=0, led=0, tick_out=0, period_done=0, dir[i]=up, mode_q=0.
- Reset sets duty[i] = i*(2^PWM_BITS/NUM_CH), truncated to PWM_BITS. Example: NUM_CH=2, PWM_BITS=4 gives duty = {0, 8}.
- Prescaler: when en=1, counts 0..CLK_DIV-1 and wraps to 0. tick is asserted while prescaler==CLK_DIV-1. With CLK_DIV=1, tick is asserted every cycle.
- tick_out is tick registered once, so it lags tick by 1 clk.
- pwm_cnt increments on tick and wraps from 2^PWM_BITS-1 to 0. wrap = tick && pwm_cnt==max.
- period_done is wrap registered once.
- mode is sampled into mode_q only on wrap. A mode change therefore takes effect at the next PWM period boundary and never truncates a period.
- Duty update occurs on wrap, in breathe and blink modes only:
  - dir up: duty+1. On reaching max, dir flips to down in the same update.
  - dir down: duty-1. On reaching 0, dir flips to up.
  - A full breath = 2*(2^PWM_BITS-1) periods.
- In off and solid modes, duty and dir hold their values.
- led[i] next-state, registered with 1 clk latency:
  - en=0 -> 0.
  - mode_q=0 -> 0.
  - mode_q=1 -> 1.
  - mode_q=2 -> (pwm_cnt < duty[i]).
  - mode_q=3 -> (dir[i]==up), i.e. a square wave with the breathe period.
- Brightness limits: duty=0 gives fully dark. duty=max gives on for 2^PWM_BITS-1 of 2^PWM_BITS ticks; only solid mode is 100%.
- en=0: prescaler, pwm_cnt, duty, dir and mode_q hold; tick_out=0 and period_done=0. Re-enable resumes from the held state with no glitch pulse.
- Simultaneous events:
  - rst wins over everything.
  - wrap and a mode change in the same cycle: the new mode is captured, and the duty update uses the new mode_q next period. The update this cycle uses the old mode_q.
- Reset mid-ramp: outputs return to reset values on the next edge; phases are re-staggered.
- Arithmetic is unsigned and width-exact. Duty never wraps below 0 or above max, because of the dir flip.

Decomposition:
- Shared package breath_pkg holds:
  - mode encodings MODE_OFF/MODE_SOLID/MODE_BREATHE/MODE_BLINK;
  - DIR_UP/DIR_DOWN;
  - the phase-offset function.
- One natural sub-module, breath_channel: the duty/dir register plus the compare/led register. It is instantiated NUM_CH times in a generate loop.
- The prescaler and pwm_cnt stay in the top level.

Test Plan:
All scenarios use NUM_CH=2, PWM_BITS=4, CLK_DIV=2 unless noted.
1. Reset and pulses: hold rst 3 clks, then release with en=1, mode=2.
   - led=00 and pulses=0 during reset.
   - tick_out pulses every 2nd clk.
   - period_done pulses every 32 clks.
2. Breathe ramp over 15 periods.
   - ch0 duty: 0,1..15; dir flips at 15, then ch0 duty decreases 14,13...
   - ch1 duty starts at 8 and flips at 15 after 7 periods.
   - ch0 led high-count per period equals its duty.
3. Mode switch mid-period: mode 2->1 at clk 10 of a period.
   - led stays PWM until the next period_done.
   - Then led=11 constantly, with duty frozen.
4. Enable gating: drop en for 20 clks mid-period.
   - led=00 and no tick_out/period_done during the gap.
   - pwm_cnt and duty are unchanged after re-enable.
5. Blink and CLK_DIV=1 corner.
   - mode=3: ch0 led high for 15 periods, low for 15.
   - With CLK_DIV=1, tick_out is asserted every clk.
6. Reset mid-ramp: assert rst while ch0 duty=9, dir=down.
   - Next clk: duty={0,8}, dir=up, led=00.
